// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the sipo_deframer block: the framing FSM state
// encoding and a helper that sizes the bit counter for a given frame width.
// Optional feature macro used by the block: SIPO_DEFRAMER_PARITY_EN.
// -----------------------------------------------------------------------------
package sipo_pkg;

   // Framing FSM states. PAR is only entered when the parity bit is enabled.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } sipo_state_e;

   // Counter must hold the values 0..width, hence width+1 codes.
   function automatic int sipo_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : sipo_pkg

// File: rtl/sipo_hold_reg.sv
// -----------------------------------------------------------------------------
// sipo_hold_reg
// One-entry output register with a valid/ready drain port and sticky overflow.
// A word offered on load_i is captured when the register is empty or is being
// drained on the same edge; otherwise it is dropped and ovf_o is set.
//
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : asynchronous reset, active low
//   load_i   in  : a completed word is offered this cycle
//   data_i   in  : offered word
//   ready_i  in  : consumer accepts data_o
//   data_o   out : held word (stable while valid_o=1 and ready_i=0)
//   valid_o  out : data_o holds an undelivered word
//   ovf_o    out : sticky, a word was dropped because the register was full
// -----------------------------------------------------------------------------
module sipo_hold_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             load_ok;

   // Room for a new word: empty now, or the current word leaves on this edge.
   assign load_ok = load_i & (~valid_q | ready_i);

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves one
      // unassigned; that is what keeps this block free of inferred latches.
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (load_ok) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end else if (valid_q & ready_i) begin
         valid_d = 1'b0;
      end
      if (load_i & ~load_ok) begin
         ovf_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign ovf_o   = ovf_q;

endmodule : sipo_hold_reg

// File: rtl/sipo_deframer.sv
// -----------------------------------------------------------------------------
// sipo_deframer
// Serial-in parallel-out deframer downstream of the piso shifter. A sof strobe
// (qualified by sv) aligns the bit counter; WIDTH valid bits form a word that
// is handed to a one-entry valid/ready output register.
//
// Optional feature: define SIPO_DEFRAMER_PARITY_EN to expect one even-parity
// bit after the data bits and to add the perr output.
//
// Parameters:
//   WIDTH     : data bits per frame (>= 2)
//   MSB_FIRST : 1 = first bit lands in o[WIDTH-1], 0 = first bit lands in o[0]
//
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : asynchronous reset, active low
//   si       in  : serial data bit
//   sv       in  : si is valid this cycle
//   sof      in  : first bit of a frame (qualified by sv)
//   o        out : parallel word
//   o_valid  out : o holds an undelivered word
//   o_ready  in  : consumer accepts o
//   ovf      out : sticky, a completed word was dropped
//   sync_err out : one-cycle pulse, sof arrived mid-frame
//   perr     out : parity mismatch on the held word (parity build only)
// -----------------------------------------------------------------------------
module sipo_deframer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   input  logic             sv,
   input  logic             sof,
   output logic [WIDTH-1:0] o,
   output logic             o_valid,
   input  logic             o_ready,
   output logic             ovf,
   output logic             sync_err
`ifdef SIPO_DEFRAMER_PARITY_EN
   ,
   output logic             perr
`endif
);

   localparam int CW = sipo_cnt_width(WIDTH);

`ifdef SIPO_DEFRAMER_PARITY_EN
   localparam int HW = WIDTH + 1;   // parity-error flag travels with the word
`else
   localparam int HW = WIDTH;
`endif

   sipo_state_e      state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             sync_err_q, sync_err_d;
   logic             done;
   logic [HW-1:0]    hold_in;
   logic [HW-1:0]    hold_out;

   // Insert one bit; the direction decides where the first bit ends up.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             b);
      if (MSB_FIRST) return {cur[WIDTH-2:0], b};
      else           return {b, cur[WIDTH-1:1]};
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      sync_err_d = 1'b0;
      done       = 1'b0;
      if (sv) begin
         if (sof) begin
            // A sof always restarts framing; only mid-frame it is an error.
            sync_err_d = (state_q != IDLE);
            shreg_d    = shift_in('0, si);
            cnt_d      = CW'(1);
            state_d    = SHIFT;
         end else begin
            case (state_q)
               SHIFT: begin
                  shreg_d = shift_in(shreg_q, si);
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_DEFRAMER_PARITY_EN
                     state_d = PAR;
`else
                     done    = 1'b1;
                     state_d = IDLE;
                     cnt_d   = '0;
`endif
                  end
               end
`ifdef SIPO_DEFRAMER_PARITY_EN
               PAR: begin
                  // Shift register already holds the full word; si is parity.
                  done    = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end
`endif
               default: ;   // IDLE without sof: bit is discarded
            endcase
         end
      end
   end

`ifdef SIPO_DEFRAMER_PARITY_EN
   // Even parity: data bits plus parity bit must XOR to zero.
   assign hold_in = {^{shreg_q, si}, shreg_q};
`else
   assign hold_in = shreg_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         sync_err_q <= sync_err_d;
      end
   end

   sipo_hold_reg #(
      .WIDTH (HW)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (done),
      .data_i  (hold_in),
      .ready_i (o_ready),
      .data_o  (hold_out),
      .valid_o (o_valid),
      .ovf_o   (ovf)
   );

   assign o        = hold_out[WIDTH-1:0];
   assign sync_err = sync_err_q;

`ifdef SIPO_DEFRAMER_PARITY_EN
   // Gating with o_valid clears the flag as soon as the word is taken.
   assign perr = hold_out[WIDTH] & o_valid;
`endif

endmodule : sipo_deframer

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-in parallel-out deframer that consumes the serial bit stream produced by the team's 4-bit `piso` shifter and rebuilds parallel words. A start-of-frame strobe aligns the bit counter, completed words are held in a one-entry output register, and the register is drained through a valid/ready handshake. It sits directly downstream of the `piso` serial output.

## Interface
- `WIDTH`, 4, data bits per frame (≥2).
- `MSB_FIRST`, 1, 1 = first received bit lands in `o[WIDTH-1]`; 0 = first bit lands in `o[0]`.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `si` in 1: serial data bit.
- `sv` in 1: `si` is valid this cycle; bits are sampled only when `sv`=1.
- `sof` in 1: first bit of a frame; qualified by `sv`.
- `o` out WIDTH: parallel word.
- `o_valid` out 1: `o` holds an undelivered word.
- `o_ready` in 1: consumer accepts `o`.
- `ovf` out 1: sticky; a completed word was dropped because the holding register was full.
- `sync_err` out 1: one-cycle pulse; `sof` arrived mid-frame.

## Operation
- States: IDLE (waiting for `sof`), SHIFT (collecting bits), PAR (parity bit, only with macro).
- IDLE: `sv`=1 with `sof`=0 → bit discarded, stay IDLE. `sv`=1 with `sof`=1 → bit stored as bit 0 of the frame, counter=1, go to SHIFT.
- SHIFT: each `sv`=1 cycle stores one bit and increments the counter. When the WIDTH-th bit is stored, the frame completes. Without macro: go to IDLE. With macro: go to PAR.
- Bit order: with `MSB_FIRST`=1, the shift register shifts left and inserts at the LSB. With `MSB_FIRST`=0, it shifts right and inserts at the MSB.
- `sof`=1 with `sv`=1 while in SHIFT or PAR: the partial frame is discarded, `sync_err` pulses, and the current bit starts a new frame (counter=1, SHIFT).
- Frame completion: if `o_valid`=0, or `o_valid & o_ready` in the same cycle, the word is loaded into `o` and `o_valid`=1. Otherwise the word is dropped, `o` is unchanged and `ovf` is set.
- Handshake: a transfer occurs on an edge where `o_valid & o_ready` = 1. `o_valid` clears after a transfer unless a new word loads on the same edge. While `o_valid`=1 and `o_ready`=0, `o` is stable.
- `ovf` stays set until reset.

## Timing
- Reset values: `o`=0, `o_valid`=0, `ovf`=0, `sync_err`=0, state=IDLE, counter=0, shift register=0.
- Latency: `o_valid` rises on the clock edge that samples the last bit of the frame, so it is visible 1 cycle after the last bit is presented. With macro, this is the parity bit.
- Gaps: `sv`=0 cycles between bits are allowed; state and counter hold.
- Back-to-back frames: a `sof` bit may immediately follow the last bit of the previous frame with no idle cycle. Throughput is one word per WIDTH (or WIDTH+1) valid bits.
- Reset asserted mid-frame: the partial frame and the held word are lost, and all outputs return to reset values asynchronously.
- `sync_err` is registered and asserts in the cycle after the offending `sof`.

## Configuration
- `SIPO_DEFRAMER_PARITY_EN` defined: each frame carries one extra even-parity bit after the WIDTH data bits, and a port `perr` (out 1) is added.
  - On parity mismatch, the word is still delivered and `perr` goes high together with `o_valid`.
  - `perr` is held with `o` and cleared on transfer.
- Not defined: the frame is exactly WIDTH bits, there is no PAR state, and there is no `perr` port.

## Structure
- Shared package `sipo_pkg`:
  - state enum `IDLE`, `SHIFT`, `PAR`;
  - counter width constant `$clog2(WIDTH+1)`.
- One natural sub-module: `sipo_hold_reg`, the one-entry valid/ready output register with overflow detection. The framing FSM and shifter stay in the top level.

## Test plan
- Aligned frame: WIDTH=4, MSB_FIRST=1, bits 1,0,1,0 on consecutive cycles with `sof` on the first and `o_ready`=1 → `o`=4'b1010 and `o_valid` high for 1 cycle after the 4th bit.
- Bit order: the same stream with MSB_FIRST=0 → `o`=4'b0101. Inserting `sv`=0 gaps between bits gives an identical result.
- Backpressure: `o_ready`=0 with two frames 1010 then 0110 → `o` stays 1010, `ovf`=1. After `o_ready`=1, `o_valid` drops and no 0110 appears.
- Simultaneous drain and load: frame 0011 completes on the same edge that 1010 transfers → `o`=0011 and `o_valid` stays high.
- Resync: `sof` on the 3rd bit of a frame → `sync_err` pulses once, and the next 4 bits starting at that `sof` form the output word.
- Reset mid-frame, plus parity:
  - Reset after 2 bits → outputs return to 0, and the next full frame decodes correctly.
  - With macro defined: data 1010 followed by parity 1 → `perr`=1.
